// File: rtl/adder_bist_checker.sv
// Exhaustive BIST engine for an N-bit adder: sweeps {A, B, Cin}, compares Sum/Cout, counts mismatches.
// Optional first-failure capture is enabled by defining ADDER_BIST_FAIL_CAPTURE_EN.
module adder_bist_checker #(
  parameter int N      = 8,
  parameter int SETTLE = 1,
  parameter int ERR_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [N-1:0]     a_o,
  output logic [N-1:0]     b_o,
  output logic             cin_o,
  input  logic [N-1:0]     sum_i,
  input  logic             cout_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [N-1:0]     fail_a,
  output logic [N-1:0]     fail_b,
  output logic             fail_cin
);
  // state  | meaning
  // IDLE   | waiting for start, outputs quiet
  // DRIVE  | vector presented, settle down-counter running
  // CHECK  | adder result compared, advance or finish
  // DONE   | run complete, done/pass held until next start
  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_CHECK, S_DONE} state_t;

  localparam int VW = 2*N + 1;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE - 1);

  state_t          state, state_nxt;
  logic [VW-1:0]   vec;
  logic [SW-1:0]   settle_cnt;
  logic            run_clr, vec_inc, settle_ld, settle_dec, chk;
  logic [N:0]      ref_sum;
  logic            mismatch;

  assign a_o   = vec[VW-1:N+1];
  assign b_o   = vec[N:1];
  assign cin_o = vec[0];

  assign ref_sum  = {1'b0, a_o} + {1'b0, b_o} + {{N{1'b0}}, cin_o};
  assign mismatch = ({cout_i, sum_i} != ref_sum);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    run_clr    = 1'b0;
    vec_inc    = 1'b0;
    settle_ld  = 1'b0;
    settle_dec = 1'b0;
    chk        = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          run_clr   = 1'b1;
          state_nxt = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (abort)                   state_nxt = S_IDLE;
        else if (settle_cnt == '0)   state_nxt = S_CHECK;
        else                         settle_dec = 1'b1;
      end
      S_CHECK: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else begin
          chk = 1'b1;
          if (vec == '1) begin
            state_nxt = S_DONE;
          end else begin
            vec_inc   = 1'b1;
            settle_ld = 1'b1;
            state_nxt = S_DRIVE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec        <= '0;
      settle_cnt <= '0;
      err_count  <= '0;
    end else if (run_clr) begin
      vec        <= '0;
      settle_cnt <= SETTLE_LD;
      err_count  <= '0;
    end else begin
      if (settle_dec) settle_cnt <= settle_cnt - SW'(1);
      if (settle_ld)  settle_cnt <= SETTLE_LD;
      if (vec_inc)    vec        <= vec + VW'(1);
      // saturate rather than wrap so a broken adder never reads as clean
      if (chk && mismatch && (err_count != '1)) err_count <= err_count + ERR_W'(1);
    end
  end

  assign busy = (state == S_DRIVE) || (state == S_CHECK);
  assign done = (state == S_DONE);
  assign pass = done && (err_count == '0);

`ifdef ADDER_BIST_FAIL_CAPTURE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_valid <= 1'b0;
      fail_a     <= '0;
      fail_b     <= '0;
      fail_cin   <= 1'b0;
    end else if (run_clr) begin
      fail_valid <= 1'b0;
      fail_a     <= '0;
      fail_b     <= '0;
      fail_cin   <= 1'b0;
    end else if (chk && mismatch && !fail_valid) begin
      fail_valid <= 1'b1;
      fail_a     <= a_o;
      fail_b     <= b_o;
      fail_cin   <= cin_o;
    end
  end
`else
  assign fail_valid = 1'b0;
  assign fail_a     = '0;
  assign fail_b     = '0;
  assign fail_cin   = 1'b0;
`endif

endmodule

// File: tb/tb_adder_bist_checker.sv
// Bench for adder_bist_checker: faulty adder models with random faults, checked against a vector-sweep reference.
module tb_adder_bist_checker;
  localparam int N      = 4;
  localparam int SETTLE = 1;
  localparam int NVEC   = 1 << (2*N + 1);
  localparam int RUN    = NVEC * (SETTLE + 1);

  logic clk, rst_n, start, abort;
  logic [N-1:0] a_o, b_o, sum_t, a_s, b_s, sum_s;
  logic cin_o, cout_t, cin_s, cout_s;
  logic busy, done, pass, busy_s, done_s, pass_s;
  logic [15:0] err_count;
  logic [3:0]  err_s;
  logic fail_valid, fail_cin, fv_s, fc_s;
  logic [N-1:0] fail_a, fail_b, fa_s, fb_s;

  int mode, kbit, sel_a, xmask;
  int n_chk = 0, n_pass = 0;

  adder_bist_checker #(.N(N), .SETTLE(SETTLE), .ERR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .a_o(a_o), .b_o(b_o), .cin_o(cin_o), .sum_i(sum_t), .cout_i(cout_t),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_valid(fail_valid), .fail_a(fail_a), .fail_b(fail_b), .fail_cin(fail_cin));

  adder_bist_checker #(.N(N), .SETTLE(SETTLE), .ERR_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .a_o(a_s), .b_o(b_s), .cin_o(cin_s), .sum_i(sum_s), .cout_i(cout_s),
    .busy(busy_s), .done(done_s), .pass(pass_s), .err_count(err_s),
    .fail_valid(fv_s), .fail_a(fa_s), .fail_b(fb_s), .fail_cin(fc_s));

  // adder under test: 0 good, 1 result bit stuck at 0, 2 sum inverted, 3 xor mask when a matches
  function automatic int faulty(int a, int b, int c, int md, int k, int sa, int xm);
    int r;
    r = a + b + c;
    case (md)
      1: r = r & ~(1 << k);
      2: r = r ^ ((1 << N) - 1);
      3: if (a == sa) r = r ^ xm;
      default: ;
    endcase
    return r;
  endfunction

  assign {cout_t, sum_t} = (N+1)'(faulty(int'(a_o), int'(b_o), int'(cin_o), mode, kbit, sel_a, xmask));
  assign {cout_s, sum_s} = (N+1)'(faulty(int'(a_s), int'(b_s), int'(cin_s), mode, kbit, sel_a, xmask));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // reference: sweep vectors in {A,B,Cin} order over the first 'upto' vectors
  task automatic model(input int upto, output int errs, output int first);
    errs = 0;
    first = -1;
    for (int v = 0; v < upto; v++) begin
      int a, b, c;
      a = v >> (N + 1);
      b = (v >> 1) & ((1 << N) - 1);
      c = v & 1;
      if (faulty(a, b, c, mode, kbit, sel_a, xmask) != a + b + c) begin
        errs++;
        if (first < 0) first = v;
      end
    end
  endtask

  // start pulse, then run until done or abort; optional extra start mid-run
  task automatic run(input int extra_at, input int abort_at, output int cycles);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cycles = 0;
    check_val("busy_after_start", busy, 1);
    check_val("err_cleared", err_count, 0);
    while (!done && cycles < RUN + 500) begin
      start = (cycles == extra_at);
      abort = (cycles == abort_at);
      @(posedge clk);
      #1;
      cycles++;
      if (abort_at >= 0 && cycles == abort_at + 1) break;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic check_full_run(input int cycles);
    int errs, first, sat;
    model(NVEC, errs, first);
    sat = (errs > 15) ? 15 : errs;
    check_val("run_cycles", cycles, RUN);
    check_val("done", done, 1);
    check_val("busy_end", busy, 0);
    check_val("err_count", err_count, errs);
    check_val("pass", pass, (errs == 0) ? 1 : 0);
    check_val("err_sat", err_s, sat);
    check_val("pass_sat", pass_s, (errs == 0) ? 1 : 0);
`ifdef ADDER_BIST_FAIL_CAPTURE_EN
    check_val("fail_valid", fail_valid, (errs != 0) ? 1 : 0);
    if (errs != 0) begin
      check_val("fail_a", fail_a, first >> (N + 1));
      check_val("fail_b", fail_b, (first >> 1) & ((1 << N) - 1));
      check_val("fail_cin", fail_cin, first & 1);
    end
`else
    check_val("fail_tied", {fail_valid, fail_a, fail_b, fail_cin}, 0);
`endif
  endtask

  initial begin
    int cyc, errs, first, v;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    mode = 0; kbit = 0; sel_a = 0; xmask = 0;
    #12;
    check_val("rst_outputs", {busy, done, pass, a_o, b_o, cin_o}, 0);
    check_val("rst_err", err_count, 0);
    check_val("rst_fail", {fail_valid, fail_a, fail_b, fail_cin}, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_val("idle_quiet", {busy, done}, 0);

    // fault sweep: good, sum[0] stuck, inverted, random stuck bit, random xor fault, good again
    for (int t = 0; t < 6; t++) begin
      case (t)
        0: mode = 0;
        1: begin mode = 1; kbit = 0; end
        2: mode = 2;
        3: begin mode = 1; kbit = $urandom_range(N, 0); end
        4: begin mode = 3; sel_a = $urandom_range((1 << N) - 1, 0); xmask = $urandom_range((1 << (N + 1)) - 1, 1); end
        default: mode = 0;
      endcase
      run(-1, -1, cyc);
      check_full_run(cyc);
      repeat ($urandom_range(4, 1)) @(posedge clk);
      #1 check_val("done_held", done, 1);
    end

    // abort in the middle of a run: partial count kept, vector frozen
    mode = 1; kbit = 0;
    run(-1, 100, cyc);
    v = 100 / (SETTLE + 1);
    model(v, errs, first);
    check_val("abort_state", {busy, done, pass}, 0);
    check_val("abort_err", err_count, errs);
    check_val("abort_vec", {a_o, b_o, cin_o}, v);
    repeat (10) @(posedge clk);
    #1 check_val("abort_frozen", {busy, done, a_o, b_o, cin_o}, v);
    mode = 0;
    run(-1, -1, cyc);
    check_full_run(cyc);

    // start pulsed mid-run is ignored
    mode = 3; sel_a = $urandom_range((1 << N) - 1, 0); xmask = $urandom_range((1 << (N + 1)) - 1, 1);
    run(300, -1, cyc);
    check_full_run(cyc);

    // asynchronous reset between edges mid-run
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (333) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_val("async_rst", {busy, done, pass, a_o, b_o, cin_o, fail_valid}, 0);
    check_val("async_rst_err", err_count, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1 check_val("post_rst_idle", {busy, done, a_o, b_o, cin_o}, 0);
    mode = 1; kbit = $urandom_range(N, 0);
    run(-1, -1, cyc);
    check_full_run(cyc);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/adder_bist_checker.md
# adder_bist_checker

Synchronous built-in self-test engine for the N-bit adder blocks. It drives every {A, B, Cin} combination into an adder under test and reads back Sum/Cout. It compares each result against an internally computed reference, counts mismatches and reports pass/fail. It does in hardware what our exhaustive adder benches do in simulation, so adder implementations can be checked on FPGA with no simulator.

## Interface
- N, default 8, operand width of the adder under test (1..12)
- SETTLE, default 1, cycles each vector is held before sampling (>=1)
- ERR_W, default 16, width of the mismatch counter
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE
- abort  in  1  one-cycle pulse; cancels a run in progress
- a_o  out  N  operand A to adder under test
- b_o  out  N  operand B to adder under test
- cin_o  out  1  carry-in to adder under test
- sum_i  in  N  Sum from adder under test
- cout_i  in  1  Cout from adder under test
- busy  out  1  run in progress
- done  out  1  run completed; level, held until next start
- pass  out  1  valid when done=1; 1 means err_count is 0
- err_count  out  ERR_W  mismatching vectors, saturating
- fail_valid, fail_a[N], fail_b[N], fail_cin  out  first failing vector (see Configuration)

## Operation
- Single clock domain; rst_n asynchronous active-low. All state and outputs reset to 0, and the FSM resets to IDLE.
- Vector counter V is 2N+1 bits, {A, B, Cin}, with Cin fastest, then B, then A. This order matches our bench loop order.
- a_o, b_o and cin_o are driven directly from registered V.
- States:
  - IDLE: busy=0. On start: clear V, err_count, pass, done and fail_*, then go to DRIVE.
  - DRIVE: hold V for SETTLE cycles (settle counter), then go to CHECK.
  - CHECK: single cycle. Compare {cout_i, sum_i} with ({1'b0,A} + {1'b0,B} + Cin), computed at N+1 bits. On mismatch, increment err_count unless it is all ones. If V is all ones, go to DONE; otherwise V=V+1 and go to DRIVE.
  - DONE: busy=0, done=1, pass=(err_count==0). start restarts exactly as from IDLE.
- start while busy: ignored.
- abort while busy: go to IDLE next cycle, with done=0 and pass=0. err_count keeps its partial value.
- abort in IDLE or DONE: ignored. If start and abort arrive in the same cycle, abort wins while busy and start wins otherwise.
- V wrap: the all-ones vector is the last vector checked. V never wraps inside a run.

## Timing
- Start sampled at edge k: busy=1 and vector 0 are presented after edge k.
- Each vector occupies SETTLE+1 cycles. Sampling happens on the CHECK-state edge.
- Run length is 2^(2N+1)·(SETTLE+1) cycles. With N=8 and SETTLE=1 that is 262144 cycles.
- done rises on the edge after the final CHECK. busy falls on the same edge.
- err_count updates on the CHECK edge. It is visible one cycle later.
- Reset mid-run: immediate return to IDLE with all outputs 0. The adder inputs go to 0.

## Configuration
- ADDER_BIST_FAIL_CAPTURE_EN defined:
  - On the first mismatch of a run, latch A, B and Cin into fail_a, fail_b and fail_cin, and set fail_valid=1.
  - Later mismatches do not overwrite the capture.
  - All four are cleared on start or reset.
- ADDER_BIST_FAIL_CAPTURE_EN undefined: fail_valid, fail_a, fail_b and fail_cin are tied to 0 and no capture registers exist.

## Test plan
- Correct behavioural adder, N=4, SETTLE=1: pulse start. Expect done 1024 cycles later, pass=1, err_count=0 and busy low.
- Adder with sum[0] stuck at 0, N=4: expect err_count=256 and pass=0. With the capture macro, expect fail_valid=1 and fail_a=0, fail_b=0, fail_cin=1.
- Adder with Sum inverted, N=4, ERR_W=4: every vector fails, so expect err_count saturated at 15 and pass=0.
- Abort at cycle 100 of a run: expect busy=0, done=0, a_o/b_o/cin_o frozen and the FSM in IDLE. A new start gives a clean full run with pass=1.
- Start pulsed during a run: expect no effect, with the run still ending at cycle 1024. Start in DONE re-runs with counters cleared.
- rst_n asserted mid-run, asynchronously between edges: expect all outputs 0 immediately. After release, expect no activity until start.
